// File: rtl/route_judge.sv
// Output-port arbiter for the 3-port router (X, Y, LOCAL).
// Each output is granted to at most one requesting input per enabled cycle, round-robin.
// The fail and select results are registered and appear one cycle after sampling.
// Optional macro JUDGE_STATS_EN adds the saturating stat_conflicts counter and its port.
module route_judge #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       dout_x,
  input  logic [1:0]       dout_y,
  input  logic [1:0]       dout_local,
  input  logic [2:0]       out_ready,
  output logic [2:0]       fail,
  output logic [1:0]       sel_x,
  output logic [1:0]       sel_y,
`ifdef JUDGE_STATS_EN
  output logic [1:0]       sel_local,
  output logic [CNT_W-1:0] stat_conflicts
`else
  output logic [1:0]       sel_local
`endif
);

  // A zero-width counter cannot be built.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("route_judge: CNT_W must be at least 1");
  end

  // Indices used throughout: X = 0, Y = 1, LOCAL = 2 (for inputs and outputs alike).
  // Codes on dout_*/sel_* are index + 1; code 0 means none.
  // Bit vectors on ports (fail, out_ready) put X in bit 2 and LOCAL in bit 0.

  typedef struct packed {
    logic       granted;    // some requester won this output
    logic [1:0] winner;     // index of the winning input
    logic [1:0] rr_next;    // pointer value to store
    logic       contended;  // ready output with two or more requesters
  } arb_t;

  logic [1:0] dout [3];
  logic [2:0] req_of_out [3];  // req_of_out[t][i]: input i requests output t
  arb_t       arb [3];

  logic [1:0] rr_q [3];
  logic [1:0] rr_d [3];
  logic [1:0] sel_q [3];
  logic [1:0] sel_d [3];
  logic [2:0] fail_q;
  logic [2:0] fail_d;
  logic       any_contention;

  assign dout[0] = dout_x;
  assign dout[1] = dout_y;
  assign dout[2] = dout_local;

  // Round-robin scan of one output; a stray pointer value of 3 is treated as 0.
  function automatic arb_t arbitrate(input logic [2:0] req, input logic rdy,
                                     input logic [1:0] rr);
    arb_t       r;
    logic [1:0] start;
    int         j;
    r         = '0;
    r.rr_next = rr;
    start     = (rr == 2'd3) ? 2'd0 : rr;
    r.contended = rdy && ((req[0] && req[1]) || (req[0] && req[2]) || (req[1] && req[2]));
    if (rdy) begin
      for (int k = 0; k < 3; k++) begin
        j = (int'(start) + k) % 3;
        if (!r.granted && req[j]) begin
          r.granted = 1'b1;
          r.winner  = 2'(j);
          r.rr_next = (j == 2) ? 2'd0 : 2'(j + 1);
        end
      end
    end
    return r;
  endfunction

  // Decode each input's direction into per-output request vectors.
  always_comb begin
    for (int t = 0; t < 3; t++) begin
      req_of_out[t] = '0;
      for (int i = 0; i < 3; i++) begin
        req_of_out[t][i] = (dout[i] == 2'(t + 1));
      end
    end
  end

  // Arbitrate every output independently and derive next fail/select/pointer values.
  always_comb begin
    fail_d         = '0;
    any_contention = 1'b0;
    for (int t = 0; t < 3; t++) begin
      arb[t]   = arbitrate(req_of_out[t], out_ready[2 - t], rr_q[t]);
      rr_d[t]  = arb[t].rr_next;
      sel_d[t] = arb[t].granted ? 2'(arb[t].winner + 2'd1) : 2'd0;
      if (arb[t].contended) begin
        any_contention = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        if (req_of_out[t][i] && !(arb[t].granted && (arb[t].winner == 2'(i)))) begin
          fail_d[2 - i] = 1'b1;
        end
      end
    end
  end

  // Result and pointer registers; enable low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q <= '0;
      for (int t = 0; t < 3; t++) begin
        sel_q[t] <= '0;
        rr_q[t]  <= '0;
      end
    end else if (enable) begin
      fail_q <= fail_d;
      for (int t = 0; t < 3; t++) begin
        sel_q[t] <= sel_d[t];
        rr_q[t]  <= rr_d[t];
      end
    end
  end

  assign fail      = fail_q;
  assign sel_x     = sel_q[0];
  assign sel_y     = sel_q[1];
  assign sel_local = sel_q[2];

`ifdef JUDGE_STATS_EN
  logic [CNT_W-1:0] stat_q;

  // Count enabled cycles with real contention; saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (enable && any_contention && (stat_q != {CNT_W{1'b1}})) begin
      stat_q <= stat_q + 1'b1;
    end
  end

  assign stat_conflicts = stat_q;
`else
  logic unused_contention;
  assign unused_contention = any_contention;
`endif

endmodule

// File: doc/route_judge.md
Name: route_judge

Overview:
- Per-cycle output-port arbiter for the 3-port router (inputs/outputs X, Y, LOCAL).
- Takes the direction code of each input's head packet and grants each output port to at most one input, round-robin.
- Registers a per-input fail bit and a per-output select code.
- Sits directly upstream of the fail-masking stage: its fail[2:0] drives that stage one cycle after the requests are sampled.

Parameters:
- CNT_W, 16, width of the statistics counter (used only with JUDGE_STATS_EN).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous reset, active-low.
- enable  input  1  advances state and outputs when 1; holds everything when 0.
- dout_x  input  2  direction request of X input: 00 NONE, 01 X, 10 Y, 11 LOCAL.
- dout_y  input  2  direction request of Y input, same encoding.
- dout_local  input  2  direction request of LOCAL input, same encoding.
- out_ready  input  3  output port can accept a packet; bit2 X, bit1 Y, bit0 LOCAL.
- fail  output  3  registered; 1 = that input's request was not granted; bit2 X, bit1 Y, bit0 LOCAL.
- sel_x  output  2  registered; input owning output X: 00 none, 01 X, 10 Y, 11 LOCAL.
- sel_y  output  2  registered; input owning output Y, same encoding.
- sel_local  output  2  registered; input owning output LOCAL, same encoding.
- stat_conflicts  output  CNT_W  present only with JUDGE_STATS_EN.

Behaviour:
- Clock and reset: single clock domain. Asynchronous active-low reset clears:
  - fail=000;
  - sel_x=sel_y=sel_local=00;
  - round-robin pointers rr_x=rr_y=rr_local=0 (priority X first);
  - stat_conflicts=0.
- Latency: requests sampled at posedge with enable=1; fail/sel valid after that edge. Exactly one cycle of latency.
- enable=0: all outputs, pointers and counters hold their values.
- Requests: input i requests output t when dout_i==t and dout_i!=00. Inputs with dout_i=00 always get fail bit 0.
- Per output t (evaluated independently):
  - No requesters: sel_t=00; rr_t unchanged.
  - out_ready[t]=0: every requester of t fails; sel_t=00; rr_t unchanged.
  - Otherwise: scan inputs starting at rr_t, in cyclic order X(0) -> Y(1) -> LOCAL(2) -> X.
    - First requester found wins: sel_t = its code, its fail bit = 0.
    - All other requesters of t fail = 1.
    - rr_t <= (winner index + 1) mod 3.
- Pointer encoding: each rr_t is a 2-bit state, legal values 0..2. Value 3 is unreachable; if it occurs it is treated as 0 and written back as winner+1.
- U-turns (e.g. the X input requesting output X) are legal and arbitrated like any other request.
- Combinational arbitration, registered outputs. No output-to-input combinational path.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). First grant after reset favours X.

Optional Feature:
- Macro: JUDGE_STATS_EN.
- Defined:
  - stat_conflicts port exists.
  - Counter increments by 1 on each enabled cycle in which at least one input fails due to contention (two or more requesters of the same ready output). Failures caused only by out_ready=0 do not count.
  - Saturates at all-ones; cleared only by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 mid-cycle with stale outputs -> fail=000 and all sel=00 immediately, without waiting for a clock edge.
- No conflict: dout_x=10, dout_y=01, dout_local=00, out_ready=111 -> next cycle fail=000, sel_x=10, sel_y=01, sel_local=00.
- Three-way contention held for 3 cycles: all inputs=11, out_ready=111 -> sel_local = 01, 10, 11 in successive cycles; fail = 011, 101, 110 respectively.
- Backpressure: dout_x=01, dout_y=01, out_ready=011 -> fail=110, sel_x=00, rr_x unchanged. Then set out_ready=111 -> sel_x=01, fail=010.
- Enable hold: after a grant, drop enable and change all inputs -> outputs stay identical for 4 cycles. Re-enable -> new results appear one cycle later.
- Stats (JUDGE_STATS_EN, CNT_W=4): 20 contention cycles -> stat_conflicts=15 and holds at 15. A backpressure-only cycle does not increment it.
